// File: rtl/instruction_executor_if.sv
// Command/status bundle between the SPI register bank and instruction_executor.
// The host side (register bank, bench) uses master; the executor uses slave.
interface instruction_executor_if;
    logic [7:0] instruction;
    logic [7:0] trigger_channel_mask;
    logic [7:0] load_cnt_ser;
    logic       adc_done;
    logic       busy;
    logic       soft_rstn;
    logic       adc_start;
    logic       readout_en;
    logic [2:0] readout_sel;
    logic [7:0] trig_out;
    logic       cmd_err;
    logic       timeout_err;

    modport master (
        output instruction, trigger_channel_mask, load_cnt_ser, adc_done,
        input  busy, soft_rstn, adc_start, readout_en, readout_sel, trig_out,
               cmd_err, timeout_err
    );

    modport slave (
        input  instruction, trigger_channel_mask, load_cnt_ser, adc_done,
        output busy, soft_rstn, adc_start, readout_en, readout_sel, trig_out,
               cmd_err, timeout_err
    );
endinterface

// File: rtl/instruction_executor.sv
// Synchronizes the SPI instruction byte into iclk and runs each new value once as a command:
// soft reset, ADC start with timeout, readout window, or masked forced trigger.
module instruction_executor #(
    parameter int unsigned ADC_TIMEOUT = 255,
    parameter int unsigned RST_CYCLES  = 4
) (
    input  logic                   iclk,
    input  logic                   rstn,
    instruction_executor_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRst, StAdcWait, StReadout} state_e;

    localparam logic [10:0] AdcLimit = 11'(ADC_TIMEOUT);
    localparam logic [10:0] RstLast  = 11'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  s1_q, s2_q, s3_q;
    logic [7:0]  last_exec_q, last_exec_d;
    logic [10:0] cnt_q, cnt_d;
    logic        adc_start_q, adc_start_d;
    logic [2:0]  readout_sel_q, readout_sel_d;
    logic [7:0]  trig_out_q, trig_out_d;
    logic        cmd_err_q, cmd_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        accept;
    logic [3:0]  opcode;

    always_comb begin
        accept        = (state_q == StIdle) && (s2_q == s3_q) && (s2_q != last_exec_q);
        opcode        = s2_q[7:4];
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_exec_d   = last_exec_q;
        adc_start_d   = 1'b0;
        readout_sel_d = readout_sel_q;
        trig_out_d    = 8'h00;
        cmd_err_d     = cmd_err_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    last_exec_d = s2_q;
                    cnt_d       = '0;
                    if ((opcode != 4'h0) && (opcode <= 4'h4)) begin
                        cmd_err_d     = 1'b0;
                        timeout_err_d = 1'b0;
                    end
                    case (opcode)
                        4'h0: state_d = StIdle;
                        4'h1: state_d = StRst;
                        4'h2: begin
                            adc_start_d = 1'b1;
                            state_d     = StAdcWait;
                        end
                        4'h3: begin
                            readout_sel_d = s2_q[2:0];
                            // Count 8*(N+1)-1 down to 0: no wrap even at N=255.
                            cnt_d         = {bus.load_cnt_ser, 3'b111};
                            state_d       = StReadout;
                        end
                        4'h4:    trig_out_d = bus.trigger_channel_mask;
                        default: cmd_err_d  = 1'b1;
                    endcase
                end
            end
            StRst: begin
                if (cnt_q == RstLast) state_d = StIdle;
                else                  cnt_d   = cnt_q + 11'd1;
            end
            StAdcWait: begin
                // A done coinciding with the start pulse is too early to be ours.
                if (bus.adc_done && !adc_start_q) begin
                    state_d = StIdle;
                end else if (cnt_q == AdcLimit) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StReadout: begin
                if (cnt_q == 11'd0) state_d = StIdle;
                else                cnt_d   = cnt_q - 11'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            s1_q          <= 8'h00;
            s2_q          <= 8'h00;
            s3_q          <= 8'h00;
            last_exec_q   <= 8'h00;
            cnt_q         <= '0;
            adc_start_q   <= 1'b0;
            readout_sel_q <= 3'd0;
            trig_out_q    <= 8'h00;
            cmd_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= bus.instruction;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            last_exec_q   <= last_exec_d;
            cnt_q         <= cnt_d;
            adc_start_q   <= adc_start_d;
            readout_sel_q <= readout_sel_d;
            trig_out_q    <= trig_out_d;
            cmd_err_q     <= cmd_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.soft_rstn   = (state_q != StRst);
    assign bus.readout_en  = (state_q == StReadout);
    assign bus.adc_start   = adc_start_q;
    assign bus.readout_sel = readout_sel_q;
    assign bus.trig_out    = trig_out_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
